// File: rtl/shape_processor_arb_pkg.sv
// Status and FSM state types for shape_processor_access_arbiter.
package shape_processor_arb_pkg;

   typedef enum logic [1:0] {
      ARB_OK       = 2'd0,
      ARB_REJECTED = 2'd1,
      ARB_MISMATCH = 2'd2
   } arb_status_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_WRITE,
      ST_ERR,
      ST_READ,
      ST_CHECK,
      ST_RESP
   } arb_state_e;

endpackage

// File: rtl/shape_processor_modeling.sv
// Control-SFR layout and KEEP encodings of the shape processor, shared by its bus clients.
package shape_processor_modeling;

   typedef struct packed {
      logic [23:0] reserved;
      logic [3:0]  operation;
      logic [3:0]  shape;
   } ctrl_sfr_reg;

   localparam logic [3:0] KEEP_SHAPE     = 4'hF;
   localparam logic [3:0] KEEP_OPERATION = 4'hF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr, cyclic.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   always_comb begin
      int unsigned cand;
      cand      = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      // Offset NUM_REQ lands back on ptr itself, so it only wins when it is the sole requester.
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = (32'(ptr) + off) % NUM_REQ;
         if (!grant_any && req[IDX_W'(cand)]) begin
            grant[IDX_W'(cand)] = 1'b1;
            grant_idx           = IDX_W'(cand);
            grant_any           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shape_processor_access_arbiter.sv
// Round-robin owner of the shape processor control-SFR bus; one write transaction per grant.
// Define SHAPE_PROCESSOR_ARB_READBACK_EN to add SFR readback and MISMATCH reporting.
module shape_processor_access_arbiter
   import shape_processor_arb_pkg::*;
   import shape_processor_modeling::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*32-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [1:0]             rsp_status,
   output logic                   write,
   output logic [31:0]            write_data,
   output logic                   read,
   input  logic [31:0]            read_data,
   input  logic                   error
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   arb_status_e        status_q, status_d;
   logic [IDX_W-1:0]   ptr_q, win_q, arb_idx;
   logic [NUM_REQ-1:0] arb_grant;
   logic               arb_any;
   logic [31:0]        sel_data;
   ctrl_sfr_reg        data_q;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) sel_data = sel_data | req_data[32*i +: 32];
      end
   end

`ifdef SHAPE_PROCESSOR_ARB_READBACK_EN
   ctrl_sfr_reg rb_view;
   logic        rb_mismatch;
   logic        unused_rb_reserved;

   assign rb_view            = read_data;
   assign unused_rb_reserved = ^rb_view.reserved;
   // KEEP fields leave the SFR untouched, so they cannot be expected to read back.
   assign rb_mismatch = ((data_q.shape != KEEP_SHAPE) && (rb_view.shape != data_q.shape)) ||
                        ((data_q.operation != KEEP_OPERATION) && (rb_view.operation != data_q.operation));
`else
   logic unused_read_data;
   assign unused_read_data = ^read_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         status_q <= ARB_OK;
         ptr_q    <= IDX_W'(NUM_REQ - 1);
         win_q    <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         if (state_q == ST_IDLE && arb_any) begin
            win_q  <= arb_idx;
            data_q <= sel_data;
         end
         if (state_q == ST_GRANT) ptr_q <= win_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      status_d   = status_q;
      req_ready  = '0;
      rsp_valid  = '0;
      rsp_status = 2'd0;
      write      = 1'b0;
      write_data = '0;
      read       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) state_d = ST_GRANT;
         end
         ST_GRANT: begin
            req_ready[win_q] = 1'b1;
            state_d          = ST_WRITE;
         end
         ST_WRITE: begin
            write      = 1'b1;
            write_data = data_q;
            state_d    = ST_ERR;
         end
         ST_ERR: begin
            if (error) begin
               status_d = ARB_REJECTED;
               state_d  = ST_RESP;
            end else begin
`ifdef SHAPE_PROCESSOR_ARB_READBACK_EN
               state_d  = ST_READ;
`else
               status_d = ARB_OK;
               state_d  = ST_RESP;
`endif
            end
         end
`ifdef SHAPE_PROCESSOR_ARB_READBACK_EN
         ST_READ: begin
            read    = 1'b1;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            status_d = rb_mismatch ? ARB_MISMATCH : ARB_OK;
            state_d  = ST_RESP;
         end
`endif
         ST_RESP: begin
            rsp_valid[win_q] = 1'b1;
            rsp_status       = status_q;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_shape_processor_access_arbiter.sv
// Self-checking bench: randomized requester traffic against a transaction-level arbitration model.
module tb_shape_processor_access_arbiter;
   import shape_processor_modeling::*;

   localparam int NUM_REQ = 4;
`ifdef SHAPE_PROCESSOR_ARB_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid;
   logic [NUM_REQ*32-1:0] req_data;
   logic [1:0]            rsp_status;
   logic                  write, read, error;
   logic [31:0]           write_data, read_data;

   int checks, fails, mptr;
   int gcyc, viol;
   logic [31:0] rq_mem [NUM_REQ][16];
   int rq_head [NUM_REQ];
   int rq_tail [NUM_REQ];
   int g_idx_q[$], g_cyc_q[$], w_cyc_q[$], r_cyc_q[$], s_idx_q[$], s_st_q[$], s_cyc_q[$];
   logic [31:0] w_data_q[$];

   shape_processor_access_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
      .write(write), .write_data(write_data), .read(read), .read_data(read_data),
      .error(error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Requester fabric, bus recorder and processor stub; everything moves 1 ns after posedge.
   // Stub: data bit31 marks an illegal write, bit30 corrupts the shape on readback.
   initial begin : monitor
      logic pw, pr;
      logic [31:0] lastw;
      logic [3:0] cur_shape, cur_op;
      pw = 1'b0; pr = 1'b0; lastw = '0; cur_shape = 4'h2; cur_op = 4'h1;
      gcyc = 0; viol = 0; req_valid = '0; req_data = '0; error = 1'b0; read_data = '0;
      for (int i = 0; i < NUM_REQ; i++) rq_head[i] = 0;
      forever begin
         @(posedge clk); #1;
         gcyc++;
         if (write && read) viol++;
         if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) viol++;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
               g_idx_q.push_back(i); g_cyc_q.push_back(gcyc); rq_head[i]++;
            end
            if (rsp_valid[i]) begin
               s_idx_q.push_back(i); s_st_q.push_back(int'(rsp_status)); s_cyc_q.push_back(gcyc);
            end
         end
         if (write) begin w_data_q.push_back(write_data); w_cyc_q.push_back(gcyc); end
         if (read) r_cyc_q.push_back(gcyc);
         error = pw ? lastw[31] : 1'b0;
         if (pw && !lastw[31]) begin
            if (lastw[3:0] != KEEP_SHAPE) cur_shape = lastw[3:0];
            if (lastw[7:4] != KEEP_OPERATION) cur_op = lastw[7:4];
         end
         read_data = pr ? {24'h0, cur_op, cur_shape ^ {3'b000, lastw[30]}} : $urandom;
         pr = read;
         if (write) lastw = write_data;
         pw = write;
         for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (rq_head[i] != rq_tail[i]);
            req_data[32*i +: 32] = rq_mem[i][rq_head[i] % 16];
         end
      end
   end

   task automatic push_req(input int r, input logic [31:0] d);
      rq_mem[r][rq_tail[r] % 16] = d;
      rq_tail[r]++;
   endtask

   task automatic wait_rsps(input int target, input int limit, output bit ok);
      int n;
      n = 0;
      while (s_idx_q.size() < target && n < limit) begin @(negedge clk); n++; end
      ok = (s_idx_q.size() >= target);
      @(negedge clk);
   endtask

   function automatic logic [31:0] mk_data(input logic [3:0] sh, input logic [3:0] op);
      logic [31:0] d;
      d = $urandom;
      d[31:30] = 2'b00;
      d[7:4] = op;
      d[3:0] = sh;
      return d;
   endfunction

   // Expected status from the stub's behaviour: illegal -> REJECTED, corrupted checked shape -> MISMATCH.
   function automatic int exp_status(input logic [31:0] d);
      if (d[31]) return 1;
      if (RB && d[30] && d[3:0] != KEEP_SHAPE) return 2;
      return 0;
   endfunction

   // Smallest valid index above ptr, otherwise the smallest valid index overall.
   function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int ptr);
      int above, lowest;
      above = -1; lowest = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lowest = i;
            if (i > ptr) above = i;
         end
      end
      return (above >= 0) ? above : lowest;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
      checks++; if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_status !== 2'd0) begin fails++; $display("FAIL reset_rsp_status: got %0d expected 0", rsp_status); end
      checks++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write: got %b expected 0", write); end
      checks++; if (write_data !== 32'h0) begin fails++; $display("FAIL reset_write_data: got %h expected 0", write_data); end
      checks++; if (read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b expected 0", read); end
      rst_n = 1'b1;
      mptr = NUM_REQ - 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fairness();
      int cnt[NUM_REQ], used[NUM_REQ];
      logic [31:0] dl[NUM_REQ][2];
      logic [NUM_REQ-1:0] mask;
      int bg, bw, bs, w;
      bit ok;
      bg = g_idx_q.size(); bw = w_data_q.size(); bs = s_idx_q.size();
      cnt = '{2, 2, 1, 1};
      for (int r = 0; r < NUM_REQ; r++) begin
         used[r] = 0;
         for (int k = 0; k < cnt[r]; k++) begin
            dl[r][k] = mk_data(4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
            dl[r][k][31] = ($urandom_range(0, 3) == 0);
            dl[r][k][30] = 1'($urandom_range(0, 1));
            push_req(r, dl[r][k]);
         end
      end
      wait_rsps(bs + 6, 120, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL fairness_timeout: got %0d responses expected 6", s_idx_q.size() - bs); return; end
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < NUM_REQ; r++) mask[r] = (used[r] < cnt[r]);
         w = model_pick(mask, mptr);
         mptr = w;
         checks++; if (g_idx_q[bg+k] !== w) begin fails++; $display("FAIL fairness_grant[%0d]: got %0d expected %0d", k, g_idx_q[bg+k], w); end
         checks++; if (w_data_q[bw+k] !== dl[w][used[w]]) begin fails++; $display("FAIL fairness_wdata[%0d]: got %h expected %h", k, w_data_q[bw+k], dl[w][used[w]]); end
         checks++; if (s_idx_q[bs+k] !== w) begin fails++; $display("FAIL fairness_rsp_idx[%0d]: got %0d expected %0d", k, s_idx_q[bs+k], w); end
         checks++; if (s_st_q[bs+k] !== exp_status(dl[w][used[w]])) begin fails++; $display("FAIL fairness_status[%0d]: got %0d expected %0d", k, s_st_q[bs+k], exp_status(dl[w][used[w]])); end
         used[w]++;
      end
   endtask

   task automatic test_single();
      logic [31:0] d;
      int bg, bw, br, bs, t0, rd_rel;
      bit ok;
      bg = g_idx_q.size(); bw = w_data_q.size(); br = r_cyc_q.size(); bs = s_idx_q.size();
      d = mk_data(4'h3, 4'h5);
      push_req(0, d);
      t0 = gcyc + 1;
      wait_rsps(bs + 1, 30, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL single_timeout: no response"); return; end
      mptr = 0;
      checks++; if (g_idx_q[bg] !== 0) begin fails++; $display("FAIL single_grant_idx: got %0d expected 0", g_idx_q[bg]); end
      checks++; if (g_cyc_q[bg] - t0 !== 1) begin fails++; $display("FAIL single_grant_cycle: got %0d expected 1", g_cyc_q[bg] - t0); end
      checks++; if (w_cyc_q[bw] - t0 !== 2) begin fails++; $display("FAIL single_write_cycle: got %0d expected 2", w_cyc_q[bw] - t0); end
      checks++; if (w_data_q[bw] !== d) begin fails++; $display("FAIL single_write_data: got %h expected %h", w_data_q[bw], d); end
      rd_rel = (r_cyc_q.size() > br) ? r_cyc_q[br] - t0 : -1;
      checks++; if (rd_rel !== (RB ? 4 : -1)) begin fails++; $display("FAIL single_read_cycle: got %0d expected %0d", rd_rel, RB ? 4 : -1); end
      checks++; if (s_cyc_q[bs] - t0 !== (RB ? 6 : 4)) begin fails++; $display("FAIL single_rsp_cycle: got %0d expected %0d", s_cyc_q[bs] - t0, RB ? 6 : 4); end
      checks++; if (s_idx_q[bs] !== 0 || s_st_q[bs] !== 0) begin fails++; $display("FAIL single_rsp: got idx %0d status %0d expected idx 0 status 0", s_idx_q[bs], s_st_q[bs]); end
   endtask

   task automatic test_illegal();
      logic [31:0] d;
      int br, bs, t0;
      bit ok;
      br = r_cyc_q.size(); bs = s_idx_q.size();
      d = mk_data(4'h7, 4'h3);
      d[31] = 1'b1;
      push_req(3, d);
      t0 = gcyc + 1;
      wait_rsps(bs + 1, 30, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL illegal_timeout: no response"); return; end
      mptr = 3;
      checks++; if (s_idx_q[bs] !== 3) begin fails++; $display("FAIL illegal_rsp_idx: got %0d expected 3", s_idx_q[bs]); end
      checks++; if (s_st_q[bs] !== 1) begin fails++; $display("FAIL illegal_status: got %0d expected 1", s_st_q[bs]); end
      checks++; if (s_cyc_q[bs] - t0 !== 4) begin fails++; $display("FAIL illegal_rsp_cycle: got %0d expected 4", s_cyc_q[bs] - t0); end
      checks++; if (r_cyc_q.size() - br !== 0) begin fails++; $display("FAIL illegal_read_count: got %0d expected 0", r_cyc_q.size() - br); end
   endtask

   task automatic test_keep();
      logic [31:0] d;
      int bs;
      bit ok;
      bs = s_idx_q.size();
      d = mk_data(KEEP_SHAPE, 4'h9);
      push_req(1, d);
      wait_rsps(bs + 1, 30, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL keep_timeout: no response"); return; end
      mptr = 1;
      checks++; if (s_idx_q[bs] !== 1 || s_st_q[bs] !== 0) begin fails++; $display("FAIL keep_rsp: got idx %0d status %0d expected idx 1 status 0", s_idx_q[bs], s_st_q[bs]); end
   endtask

   task automatic test_mismatch();
      logic [31:0] d;
      int bs;
      bit ok;
      bs = s_idx_q.size();
      d = mk_data(4'h6, 4'h2);
      d[30] = 1'b1;
      push_req(2, d);
      wait_rsps(bs + 1, 30, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok) begin fails++; $display("FAIL mismatch_timeout: no response"); return; end
      mptr = 2;
      checks++; if (s_idx_q.size() - bs !== 1) begin fails++; $display("FAIL mismatch_rsp_count: got %0d expected 1", s_idx_q.size() - bs); end
      checks++; if (s_idx_q[bs] !== 2) begin fails++; $display("FAIL mismatch_rsp_idx: got %0d expected 2", s_idx_q[bs]); end
      checks++; if (s_st_q[bs] !== exp_status(d)) begin fails++; $display("FAIL mismatch_status: got %0d expected %0d", s_st_q[bs], exp_status(d)); end
   endtask

   task automatic test_busy();
      logic [31:0] d[3];
      int who[3] = '{1, 3, 0};
      int bg, bs, n;
      bit ok;
      bg = g_idx_q.size(); bs = s_idx_q.size();
      for (int k = 0; k < 3; k++) begin
         d[k] = mk_data(4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
         d[k][31] = 1'($urandom_range(0, 1));
      end
      push_req(1, d[0]);
      n = 0;
      while (g_idx_q.size() == bg && n < 20) begin @(negedge clk); n++; end
      push_req(3, d[1]);
      push_req(0, d[2]);
      wait_rsps(bs + 3, 60, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL busy_timeout: got %0d responses expected 3", s_idx_q.size() - bs); return; end
      mptr = 0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (s_idx_q[bs+k] !== who[k]) begin fails++; $display("FAIL busy_rsp_idx[%0d]: got %0d expected %0d", k, s_idx_q[bs+k], who[k]); end
         checks++; if (s_st_q[bs+k] !== exp_status(d[k])) begin fails++; $display("FAIL busy_status[%0d]: got %0d expected %0d", k, s_st_q[bs+k], exp_status(d[k])); end
      end
   endtask

   task automatic test_random();
      for (int round = 0; round < 12; round++) begin
         int cnt[NUM_REQ], used[NUM_REQ];
         logic [31:0] dl[NUM_REQ][3];
         logic [NUM_REQ-1:0] mask;
         int bg, bw, bs, total, w;
         bit ok;
         bg = g_idx_q.size(); bw = w_data_q.size(); bs = s_idx_q.size();
         total = 0;
         for (int r = 0; r < NUM_REQ; r++) begin
            cnt[r] = $urandom_range(0, 2) + ((r == round % NUM_REQ) ? 1 : 0);
            used[r] = 0;
            for (int k = 0; k < cnt[r]; k++) begin
               dl[r][k] = $urandom;
               dl[r][k][31] = ($urandom_range(0, 3) == 0);
               push_req(r, dl[r][k]);
            end
            total += cnt[r];
         end
         wait_rsps(bs + total, 10 * total + 20, ok);
         checks++;
         if (!ok) begin fails++; $display("FAIL random_timeout[%0d]: got %0d expected %0d", round, s_idx_q.size() - bs, total); return; end
         for (int k = 0; k < total; k++) begin
            for (int r = 0; r < NUM_REQ; r++) mask[r] = (used[r] < cnt[r]);
            w = model_pick(mask, mptr);
            mptr = w;
            checks++; if (g_idx_q[bg+k] !== w) begin fails++; $display("FAIL random_grant[%0d.%0d]: got %0d expected %0d", round, k, g_idx_q[bg+k], w); end
            checks++; if (w_data_q[bw+k] !== dl[w][used[w]]) begin fails++; $display("FAIL random_wdata[%0d.%0d]: got %h expected %h", round, k, w_data_q[bw+k], dl[w][used[w]]); end
            checks++; if (s_idx_q[bs+k] !== w || s_st_q[bs+k] !== exp_status(dl[w][used[w]])) begin
               fails++; $display("FAIL random_rsp[%0d.%0d]: got idx %0d status %0d expected idx %0d status %0d",
                                 round, k, s_idx_q[bs+k], s_st_q[bs+k], w, exp_status(dl[w][used[w]]));
            end
            used[w]++;
         end
      end
      checks++; if (viol !== 0) begin fails++; $display("FAIL bus_exclusive: got %0d violations expected 0", viol); end
   endtask

   task automatic test_reset_mid();
      int bs, bg, n;
      bit ok;
      push_req(1, mk_data(4'h4, 4'h4));
      n = 0;
      while (write !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (write !== 1'b1) begin fails++; $display("FAIL resetmid_no_write: write never seen"); return; end
      bs = s_idx_q.size();
      rst_n = 1'b0;
      #1;
      checks++; if ({req_ready, rsp_valid, rsp_status, write, read} !== '0 || write_data !== 32'h0) begin
         fails++; $display("FAIL resetmid_outputs: got ready %b rsp %b st %0d wr %b rd %b wd %h expected all 0",
                           req_ready, rsp_valid, rsp_status, write, read, write_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mptr = NUM_REQ - 1;
      repeat (8) @(negedge clk);
      checks++; if (s_idx_q.size() !== bs) begin fails++; $display("FAIL resetmid_no_rsp: got %0d responses expected 0", s_idx_q.size() - bs); end
      bg = g_idx_q.size();
      push_req(2, mk_data(4'h1, 4'h2));
      push_req(0, mk_data(4'h3, 4'h2));
      wait_rsps(bs + 2, 40, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL resetmid_timeout: got %0d responses expected 2", s_idx_q.size() - bs); return; end
      checks++; if (g_idx_q[bg] !== model_pick(4'b0101, mptr)) begin fails++; $display("FAIL resetmid_first_grant: got %0d expected %0d", g_idx_q[bg], model_pick(4'b0101, mptr)); end
      checks++; if (g_idx_q[bg+1] !== 2) begin fails++; $display("FAIL resetmid_second_grant: got %0d expected 2", g_idx_q[bg+1]); end
   endtask

   initial begin
      checks = 0; fails = 0; mptr = NUM_REQ - 1; rst_n = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) rq_tail[r] = 0;
      test_reset();
      test_fairness();
      test_single();
      test_illegal();
      test_keep();
      test_mismatch();
      test_busy();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
